jcquant_q1: RTL and testbench

- Forward quantizer for the JPEG encode path; the inverse of the decode-side dequantizer stage.
- Loads a 64-entry quantization table from a table stream.
- Then divides each incoming 16-bit signed DCT coefficient by its table entry, rounding to nearest, using a serial restoring divider.
- Sits between the forward-DCT operator and the zigzag/entropy stage, using the standard _d/_e/_v/_b token-stream protocol.

---
 rtl/jcquant_q1.sv | 195 +++++++++++++++++++
 tb/tb_jcquant_q1.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jcquant_q1.sv
// ---------------------------------------------------------------------------
// jcquant_q1 -- forward quantizer for the JPEG encode path.
//
// Loads a quantization table from qStream, then divides each signed DCT
// coefficient from inStream by the table entry for its position in the
// block. Rounding is to nearest, with halves rounded away from zero. A
// serial restoring divider produces one quotient bit per cycle. Results
// leave on outStream. All four streams use the _d/_e/_v/_b token protocol:
// a token moves on a rising edge when _v=1 and _b=0.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   qStream_*    quantization table entries in (QW-bit unsigned), _b out
//   inStream_*   DCT coefficients in (DW-bit signed, block order), _b out
//   outStream_*  quantized coefficients out (DW-bit signed), _b in
// ---------------------------------------------------------------------------
module jcquant_q1 #(
  parameter int DW    = 16,
  parameter int QW    = 8,
  parameter int NCOEF = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [QW-1:0] qStream_d,
  input  logic          qStream_e,
  input  logic          qStream_v,
  output logic          qStream_b,
  input  logic [DW-1:0] inStream_d,
  input  logic          inStream_e,
  input  logic          inStream_v,
  output logic          inStream_b,
  output logic [DW-1:0] outStream_d,
  output logic          outStream_e,
  output logic          outStream_v,
  input  logic          outStream_b
);

  localparam int IW = $clog2(NCOEF);
  localparam int CW = $clog2(DW + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW);

  typedef enum logic [2:0] {LOADQ, IDLE, DIV, EMIT, EOS, DONE} stateT;

  stateT         state;
  logic [IW-1:0] loadIdx;
  logic [IW-1:0] coefIdx;
  logic [QW-1:0] qTable [NCOEF];

  // Divider working registers: nq holds the dividend. It shifts out at the
  // top while quotient bits shift in at the bottom. rem always stays below
  // the divisor, so QW bits are enough to hold it.
  logic          negRes;
  logic [QW-1:0] divisor;
  logic [QW-1:0] rem;
  logic [DW:0]   nq;
  logic [CW-1:0] stepCnt;

  // Combinational helpers
  logic [QW:0]   trial;
  logic          qBit;
  logic [QW-1:0] remNext;
  logic [DW-1:0] quotLow;
  logic [DW-1:0] result;
  logic [DW:0]   inExt;
  logic [DW:0]   inMag;
  logic [QW-1:0] qEntry;
  logic [DW:0]   dividend;
  logic          tableWrite;
  logic          inAccept;

  // One restoring-division step. The final step also forms the signed
  // result directly, so EMIT can start on the cycle right after the last
  // quotient bit. The quotient always fits in DW bits once truncated.
  // |-32768| with Q=1 becomes 0x8000, and negating that gives -32768 again.
  always_comb begin
    trial   = {rem, nq[DW]};
    qBit    = (trial >= {1'b0, divisor});
    remNext = qBit ? (trial[QW-1:0] - divisor) : trial[QW-1:0];
    quotLow = {nq[DW-2:0], qBit};
    result  = negRes ? -quotLow : quotLow;
  end

  // Front end of the divide. The magnitude is computed DW+1 bits wide so
  // that -32768 is exact. Adding floor(Q/2) before a truncating divide
  // turns it into round-half-away-from-zero on the magnitude.
  always_comb begin
    inExt      = {inStream_d[DW-1], inStream_d};
    inMag      = inStream_d[DW-1] ? -inExt : inExt;
    qEntry     = qTable[coefIdx];
    dividend   = inMag + {{(DW + 2 - QW){1'b0}}, qEntry[QW-1:1]};
    tableWrite = qStream_v && !qStream_b;
    inAccept   = inStream_v && !inStream_b;
  end

  // Main controller. All stream outputs are registered and updated together
  // with the state, so no _v input ever reaches a _b output combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= LOADQ;
      loadIdx     <= '0;
      coefIdx     <= '0;
      for (int i = 0; i < NCOEF; i++) qTable[i] <= QW'(1);
      negRes      <= 1'b0;
      divisor     <= QW'(1);
      rem         <= '0;
      nq          <= '0;
      stepCnt     <= '0;
      qStream_b   <= 1'b0;
      inStream_b  <= 1'b1;
      outStream_v <= 1'b0;
      outStream_e <= 1'b0;
      outStream_d <= '0;
    end else begin
      case (state)
        LOADQ: begin
          if (tableWrite) begin
            if (qStream_e) begin
              state      <= IDLE;
              qStream_b  <= 1'b1;
              inStream_b <= 1'b0;
            end else begin
              // A zero entry would make the divide meaningless, so it is stored as 1
              qTable[loadIdx] <= (qStream_d == '0) ? QW'(1) : qStream_d;
              loadIdx         <= loadIdx + 1'b1;
              if (loadIdx == LAST_IDX) begin
                state      <= IDLE;
                qStream_b  <= 1'b1;
                inStream_b <= 1'b0;
              end
            end
          end
        end

        IDLE: begin
          if (inAccept) begin
            inStream_b <= 1'b1;
            if (inStream_e) begin
              state       <= EOS;
              outStream_v <= 1'b1;
              outStream_e <= 1'b1;
              outStream_d <= '0;
            end else begin
              state   <= DIV;
              negRes  <= inStream_d[DW-1];
              divisor <= qEntry;
              rem     <= '0;
              nq      <= dividend;
              stepCnt <= '0;
            end
          end
        end

        DIV: begin
          rem <= remNext;
          nq  <= {nq[DW-1:0], qBit};
          if (stepCnt == LAST_STEP) begin
            state       <= EMIT;
            outStream_v <= 1'b1;
            outStream_e <= 1'b0;
            outStream_d <= result;
          end else begin
            stepCnt <= stepCnt + 1'b1;
          end
        end

        EMIT: begin
          if (!outStream_b) begin
            state       <= IDLE;
            outStream_v <= 1'b0;
            inStream_b  <= 1'b0;
            coefIdx     <= (coefIdx == LAST_IDX) ? '0 : coefIdx + 1'b1;
          end
        end

        EOS: begin
          if (!outStream_b) begin
            state       <= DONE;
            outStream_v <= 1'b0;
            outStream_e <= 1'b0;
          end
        end

        default: begin
          // DONE: terminal until reset
          outStream_v <= 1'b0;
          inStream_b  <= 1'b1;
          qStream_b   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jcquant_q1.sv
// ---------------------------------------------------------------------------
// tb_jcquant_q1 -- self-checking bench for the jcquant_q1 forward quantizer.
// Expected results come from a plain integer rounding model, or from fixed
// constants for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_jcquant_q1;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  qStream_d;
  logic        qStream_e, qStream_v, qStream_b;
  logic [15:0] inStream_d;
  logic        inStream_e, inStream_v, inStream_b;
  logic [15:0] outStream_d;
  logic        outStream_e, outStream_v, outStream_b;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int outXfers   = 0;
  logic [7:0] tblVals [64];

  jcquant_q1 dut (
    .clock(clock), .reset(reset),
    .qStream_d(qStream_d), .qStream_e(qStream_e), .qStream_v(qStream_v), .qStream_b(qStream_b),
    .inStream_d(inStream_d), .inStream_e(inStream_e), .inStream_v(inStream_v), .inStream_b(inStream_b),
    .outStream_d(outStream_d), .outStream_e(outStream_e), .outStream_v(outStream_v), .outStream_b(outStream_b)
  );

  always #5 clock = ~clock;

  // Free-running edge counter and output-transfer counter used for timing checks
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (outStream_v && !outStream_b) outXfers <= outXfers + 1;
  end

  // Reference model: divide the magnitude, rounding half away from zero;
  // a zero table entry acts as 1
  function automatic logic [15:0] refQuant(input int x, input int q);
    int qq;
    int a;
    int r;
    qq = (q == 0) ? 1 : q;
    a  = (x < 0) ? -x : x;
    r  = (a + qq / 2) / qq;
    if (x < 0) r = -r;
    return r[15:0];
  endfunction

  task automatic doReset();
    reset       = 1'b1;
    qStream_d   = '0; qStream_e  = 1'b0; qStream_v  = 1'b0;
    inStream_d  = '0; inStream_e = 1'b0; inStream_v = 1'b0;
    outStream_b = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Sends table entries tblVals[first .. first+n-1], then an optional EOS token
  task automatic loadTable(input int first, input int n, input bit eos);
    for (int i = first; i < first + n; i++) begin
      @(negedge clock);
      qStream_d = tblVals[i]; qStream_e = 1'b0; qStream_v = 1'b1;
      @(posedge clock);
    end
    if (eos) begin
      @(negedge clock);
      qStream_e = 1'b1; qStream_v = 1'b1;
      @(posedge clock);
    end
    @(negedge clock);
    qStream_v = 1'b0; qStream_e = 1'b0;
  endtask

  // Called at a negedge. Offers x, waits for acceptance, then waits for the
  // result. lat = number of edges from the accept edge to the first edge
  // that sees outStream_v=1. If consume is set, the result transfers and the
  // task returns at the following negedge.
  task automatic applyStimulus(input logic [15:0] x, input bit consume,
                               output logic [15:0] y, output int lat,
                               output int accCyc, output bit ok);
    int w;
    int k;
    ok = 1'b0; y = '0; lat = 0; accCyc = 0;
    inStream_d = x; inStream_e = 1'b0; inStream_v = 1'b1;
    w = 0;
    while (inStream_b && w < 50) begin @(negedge clock); w++; end
    if (inStream_b) begin inStream_v = 1'b0; return; end
    @(posedge clock);
    @(negedge clock);
    inStream_v = 1'b0;
    accCyc = cyc;
    k = 0;
    while (!outStream_v && k < 100) begin @(negedge clock); k++; end
    if (!outStream_v) return;
    lat = k + 1;
    y   = outStream_d;
    ok  = 1'b1;
    if (consume) begin @(posedge clock); @(negedge clock); end
  endtask

  task automatic test_reset();
    doReset();
    compared++;
    if (outStream_v !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_outv: got %b expected 0", outStream_v); end
    compared++;
    if (outStream_e !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_oute: got %b expected 0", outStream_e); end
    compared++;
    if (outStream_d !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_outd: got %h expected 0000", outStream_d); end
    compared++;
    if (qStream_b !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_qb: got %b expected 0", qStream_b); end
    compared++;
    if (inStream_b !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_inb: got %b expected 1", inStream_b); end
  endtask

  task automatic test_basic();
    logic signed [15:0] xs [6] = '{16'sd100, -16'sd100, 16'sd8, -16'sd8, 16'sd7, 16'sd0};
    int expd [6] = '{6, -6, 1, -1, 0, 0};
    logic [15:0] y;
    int lat, acc, prevAcc;
    bit ok;
    doReset();
    for (int i = 0; i < 64; i++) tblVals[i] = 8'd16;
    loadTable(0, 64, 1'b0);
    prevAcc = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(xs[i], 1'b1, y, lat, acc, ok);
      compared++;
      if (!ok || y !== 16'(expd[i])) begin
        mismatched++; $display("[TB] FAIL basic_result[%0d]: got %h ok=%b expected %h", i, y, ok, 16'(expd[i]));
      end
      compared++;
      if (lat !== 18) begin mismatched++; $display("[TB] FAIL basic_latency[%0d]: got %0d expected 18", i, lat); end
      if (i > 0) begin
        compared++;
        if (acc - prevAcc !== 19) begin
          mismatched++; $display("[TB] FAIL basic_throughput[%0d]: got %0d expected 19", i, acc - prevAcc);
        end
      end
      prevAcc = acc;
    end
  endtask

  task automatic test_index_wrap();
    logic [15:0] y;
    int lat, acc;
    bit ok;
    doReset();
    for (int i = 0; i < 64; i++) tblVals[i] = 8'(i + 1);
    loadTable(0, 64, 1'b0);
    for (int k = 0; k < 128; k++) begin
      applyStimulus(16'd1000, 1'b1, y, lat, acc, ok);
      compared++;
      if (!ok || y !== refQuant(1000, (k % 64) + 1)) begin
        mismatched++; $display("[TB] FAIL wrap_result[%0d]: got %h expected %h", k, y, refQuant(1000, (k % 64) + 1));
      end
    end
  endtask

  task automatic test_extremes();
    logic signed [15:0] xs [4] = '{-16'sd32768, 16'sd32767, -16'sd32768, 16'sd32767};
    logic [15:0] y;
    int lat, acc;
    bit ok;
    doReset();
    for (int i = 0; i < 64; i++) tblVals[i] = 8'd1;
    tblVals[0] = 8'd0;
    tblVals[2] = 8'd255;
    tblVals[3] = 8'd2;
    loadTable(0, 64, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(xs[i], 1'b1, y, lat, acc, ok);
      compared++;
      if (!ok || y !== refQuant(int'(xs[i]), int'(tblVals[i]))) begin
        mismatched++; $display("[TB] FAIL extreme_result[%0d]: got %h expected %h", i, y, refQuant(int'(xs[i]), int'(tblVals[i])));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] y;
    int lat, acc, x0;
    bit ok;
    doReset();
    for (int i = 0; i < 64; i++) tblVals[i] = 8'd16;
    loadTable(0, 64, 1'b0);
    outStream_b = 1'b1;
    applyStimulus(16'd80, 1'b0, y, lat, acc, ok);
    compared++;
    if (!ok || y !== 16'd5) begin mismatched++; $display("[TB] FAIL bp_result: got %h expected 0005", y); end
    x0 = outXfers;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      compared++;
      if (outStream_v !== 1'b1 || outStream_d !== 16'd5 || inStream_b !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%h inb=%b expected v=1 d=0005 inb=1", i, outStream_v, outStream_d, inStream_b);
      end
    end
    outStream_b = 1'b0;
    repeat (4) @(negedge clock);
    compared++;
    if (outXfers - x0 !== 1) begin mismatched++; $display("[TB] FAIL bp_transfers: got %0d expected 1", outXfers - x0); end
    compared++;
    if (outStream_v !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_release_v: got %b expected 0", outStream_v); end
  endtask

  task automatic test_random();
    logic signed [15:0] x;
    logic [15:0] y, e;
    int lat, acc, idx, r;
    bit ok;
    doReset();
    for (int i = 0; i < 64; i++) begin
      r = int'($urandom_range(0, 9));
      tblVals[i] = (r == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    end
    loadTable(0, 64, 1'b0);
    idx = 0;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      x = (r == 0) ? -16'sd32768 : (r == 1) ? 16'sd32767 : 16'($urandom);
      e = refQuant(int'(x), int'(tblVals[idx]));
      applyStimulus(x, 1'b1, y, lat, acc, ok);
      compared++;
      if (!ok || y !== e) begin
        mismatched++; $display("[TB] FAIL random_result[%0d]: x=%0d q=%0d got %h expected %h", n, x, tblVals[idx], y, e);
      end
      idx = (idx + 1) % 64;
    end
  endtask

  task automatic test_partial_eos();
    int expd [4] = '{4, 2, 1, 35};
    logic [15:0] y;
    int lat, acc, x0, w;
    bit ok;
    doReset();
    tblVals[0] = 8'd10; tblVals[1] = 8'd20; tblVals[2] = 8'd30;
    loadTable(0, 3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'd35, 1'b1, y, lat, acc, ok);
      compared++;
      if (!ok || y !== 16'(expd[i])) begin
        mismatched++; $display("[TB] FAIL eos_result[%0d]: got %h expected %h", i, y, 16'(expd[i]));
      end
    end
    x0 = outXfers;
    inStream_d = 16'h1234; inStream_e = 1'b1; inStream_v = 1'b1;
    @(posedge clock);
    @(negedge clock);
    inStream_v = 1'b0; inStream_e = 1'b0;
    w = 0;
    while (!outStream_v && w < 50) begin @(negedge clock); w++; end
    compared++;
    if (outStream_v !== 1'b1 || outStream_e !== 1'b1 || outStream_d !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL eos_token: got v=%b e=%b d=%h expected v=1 e=1 d=0000", outStream_v, outStream_e, outStream_d);
    end
    inStream_v = 1'b1; qStream_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      compared++;
      if (inStream_b !== 1'b1 || qStream_b !== 1'b1 || outStream_v !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL done_state[%0d]: got inb=%b qb=%b v=%b expected inb=1 qb=1 v=0", i, inStream_b, qStream_b, outStream_v);
      end
    end
    inStream_v = 1'b0; qStream_v = 1'b0;
    compared++;
    if (outXfers - x0 !== 1) begin mismatched++; $display("[TB] FAIL eos_transfers: got %0d expected 1", outXfers - x0); end
  endtask

  task automatic test_reset_mid_div();
    logic [15:0] y;
    int lat, acc;
    bit ok;
    doReset();
    for (int i = 0; i < 64; i++) tblVals[i] = 8'd16;
    loadTable(0, 64, 1'b0);
    inStream_d = 16'd100; inStream_e = 1'b0; inStream_v = 1'b1;
    @(posedge clock);
    @(negedge clock);
    inStream_v = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    compared++;
    if (outStream_v !== 1'b0 || qStream_b !== 1'b0 || inStream_b !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL div_reset_async: got v=%b qb=%b inb=%b expected v=0 qb=0 inb=1", outStream_v, qStream_b, inStream_b);
    end
    @(negedge clock);
    reset = 1'b0;

    // Reset while the result sits stalled in EMIT
    loadTable(0, 64, 1'b0);
    outStream_b = 1'b1;
    applyStimulus(16'd80, 1'b0, y, lat, acc, ok);
    #3 reset = 1'b1;
    #1;
    compared++;
    if (!ok || outStream_v !== 1'b0) begin
      mismatched++; $display("[TB] FAIL emit_reset_async: got v=%b ok=%b expected v=0 ok=1", outStream_v, ok);
    end
    @(negedge clock);
    reset = 1'b0;
    outStream_b = 1'b0;

    // Nothing may be accepted before the table is fully reloaded
    inStream_d = 16'd100; inStream_v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      compared++;
      if (inStream_b !== 1'b1 || outStream_v !== 1'b0) begin
        mismatched++; $display("[TB] FAIL reload_block[%0d]: got inb=%b v=%b expected inb=1 v=0", i, inStream_b, outStream_v);
      end
    end
    inStream_v = 1'b0;
    for (int i = 0; i < 64; i++) tblVals[i] = 8'd3;
    loadTable(0, 63, 1'b0);
    compared++;
    if (inStream_b !== 1'b1) begin mismatched++; $display("[TB] FAIL reload_63: got inb=%b expected 1", inStream_b); end
    loadTable(63, 1, 1'b0);
    compared++;
    if (inStream_b !== 1'b0 || qStream_b !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reload_64: got inb=%b qb=%b expected inb=0 qb=1", inStream_b, qStream_b);
    end
    applyStimulus(16'd100, 1'b1, y, lat, acc, ok);
    compared++;
    if (!ok || y !== refQuant(100, 3)) begin
      mismatched++; $display("[TB] FAIL reload_result: got %h expected %h", y, refQuant(100, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_index_wrap();
    test_extremes();
    test_backpressure();
    test_random();
    test_partial_eos();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
